// File: rtl/kb_scan_rx.sv
// kb_scan_rx: PS/2 keyboard receiver feeding the UART TX FIFO.
//
// Resynchronises and de-glitches the PS/2 clock, then deserialises
// 11-bit frames (start, d0..d7 LSB first, odd parity, stop). Break
// sequences (F0 xx) and extended prefixes (E0) are dropped. Each
// remaining make code is written to the TX FIFO with a one-cycle strobe.
//
// Ports:
//   clk         system clock (50 MHz)
//   reset       asynchronous active-low reset
//   ps2c, ps2d  PS/2 clock and data pins (asynchronous)
//   tx_full     UART TX FIFO full; sampled only in the CHECK cycle
//   wr_uart     one-cycle FIFO write strobe
//   w_data      scan code written with wr_uart; holds the last write
//   frame_err   one-cycle pulse: parity error, bad stop bit or timeout
//   ovr_err     one-cycle pulse: make code dropped because tx_full=1
//   busy        high while a frame is in progress
//   o_dbg_state current FSM state (0=IDLE, 1=RX, 2=CHECK)
//
// Handshake: wr_uart is a fire-and-forget valid. There is no ready
// back-pressure; tx_full is checked once in CHECK and a code arriving
// while it is high is dropped and reported via ovr_err.
module kb_scan_rx #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 5000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2c,
    input  logic       ps2d,
    input  logic       tx_full,
    output logic       wr_uart,
    output logic [7:0] w_data,
    output logic       frame_err,
    output logic       ovr_err,
    output logic       busy,
    output logic [1:0] o_dbg_state
);

    localparam int TW = $clog2(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RX    = 2'd1,
        S_CHECK = 2'd2
    } state_t;

    // Input conditioning
    logic                  r_c_meta, r_c_sync;
    logic                  r_d_meta, r_d_sync;
    logic [FILTER_LEN-1:0] r_filt;
    logic                  r_fclk;
    logic                  r_fall;
    logic                  w_fclk_next;

    // Filtered level only moves when the whole window agrees; mixed
    // windows (glitches) hold the previous level.
    always_comb begin
        w_fclk_next = r_fclk;
        if (&r_filt)
            w_fclk_next = 1'b1;
        else if (~|r_filt)
            w_fclk_next = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_c_meta <= 1'b1;
            r_c_sync <= 1'b1;
            r_d_meta <= 1'b1;
            r_d_sync <= 1'b1;
            r_filt   <= '1;
            r_fclk   <= 1'b1;
            r_fall   <= 1'b0;
        end else begin
            r_c_meta <= ps2c;
            r_c_sync <= r_c_meta;
            r_d_meta <= ps2d;
            r_d_sync <= r_d_meta;
            r_filt   <= {r_filt[FILTER_LEN-2:0], r_c_sync};
            r_fclk   <= w_fclk_next;
            r_fall   <= r_fclk & ~w_fclk_next;
        end
    end

    // Frame FSM
    state_t          r_state, w_state_nx;
    logic [3:0]      r_n, w_n_nx;
    logic [9:0]      r_sr, w_sr_nx;
    logic [TW-1:0]   r_tcnt, w_tcnt_nx;
    logic            r_brk, w_brk_nx;
    logic            r_wr, w_wr_nx;
    logic [7:0]      r_wdata, w_wdata_nx;
    logic            r_ferr, w_ferr_nx;
    logic            r_ovr, w_ovr_nx;
    logic            w_valid;
    logic [7:0]      w_code;

    // After 10 shifts: sr[7:0]=data, sr[8]=parity, sr[9]=stop.
    assign w_code  = r_sr[7:0];
    assign w_valid = r_sr[9] & (^r_sr[8:0]);

    always_comb begin
        w_state_nx = r_state;
        w_n_nx     = r_n;
        w_sr_nx    = r_sr;
        w_tcnt_nx  = r_tcnt;
        w_brk_nx   = r_brk;
        w_wr_nx    = 1'b0;
        w_wdata_nx = r_wdata;
        w_ferr_nx  = 1'b0;
        w_ovr_nx   = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A high data bit on an edge is a spurious edge, not a start.
                if (r_fall && !r_d_sync) begin
                    w_state_nx = S_RX;
                    w_n_nx     = 4'd9;
                    w_tcnt_nx  = '0;
                end
            end
            S_RX: begin
                if (r_fall) begin
                    w_sr_nx   = {r_d_sync, r_sr[9:1]};
                    w_tcnt_nx = '0;
                    if (r_n == 4'd0)
                        w_state_nx = S_CHECK;
                    else
                        w_n_nx = r_n - 4'd1;
                end else if (r_tcnt == TW'(TIMEOUT_CYC - 1)) begin
                    w_state_nx = S_IDLE;
                    w_ferr_nx  = 1'b1;
                end else begin
                    w_tcnt_nx = r_tcnt + TW'(1);
                end
            end
            S_CHECK: begin
                w_state_nx = S_IDLE;
                if (!w_valid) begin
                    w_ferr_nx = 1'b1;
                end else if (w_code == 8'hF0) begin
                    w_brk_nx = 1'b1;
                end else if (r_brk) begin
                    // Code following F0 is the released key: swallow it.
                    w_brk_nx = 1'b0;
                end else if (w_code == 8'hE0) begin
                    w_brk_nx = r_brk;
                end else if (!tx_full) begin
                    w_wr_nx    = 1'b1;
                    w_wdata_nx = w_code;
                end else begin
                    w_ovr_nx = 1'b1;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_n     <= 4'd0;
            r_sr    <= '0;
            r_tcnt  <= '0;
            r_brk   <= 1'b0;
            r_wr    <= 1'b0;
            r_wdata <= 8'h00;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_n     <= w_n_nx;
            r_sr    <= w_sr_nx;
            r_tcnt  <= w_tcnt_nx;
            r_brk   <= w_brk_nx;
            r_wr    <= w_wr_nx;
            r_wdata <= w_wdata_nx;
            r_ferr  <= w_ferr_nx;
            r_ovr   <= w_ovr_nx;
        end
    end

    assign wr_uart     = r_wr;
    assign w_data      = r_wdata;
    assign frame_err   = r_ferr;
    assign ovr_err     = r_ovr;
    assign busy        = (r_state != S_IDLE);
    assign o_dbg_state = r_state;

endmodule
